// File: rtl/fifo_pkg.sv
// Shared helpers for the register-file FIFO: pointer sizing and
// threshold legality checks used at elaboration time.
package fifo_pkg;

  // Pointers carry one extra wrap bit above the storage address.
  function automatic int ptr_width(input int addrw);
    return addrw + 1;
  endfunction

  // Almost-full threshold must lie in 1..DEPTH.
  function automatic bit afull_th_legal(input int addrw, input int th);
    return (th >= 1) && (th <= (1 << addrw));
  endfunction

  // Almost-empty threshold must lie in 0..DEPTH-1.
  function automatic bit aempty_th_legal(input int addrw, input int th);
    return (th >= 0) && (th <= (1 << addrw) - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATAW storage array: clocked write port, asynchronous read port.
module fifo_mem #(
  parameter int ADDRW = 4,
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [DATAW-1:0] wr_data,
  input  logic [ADDRW-1:0] rd_addr,
  output logic [DATAW-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDRW;

  logic [DATAW-1:0] mem [DEPTH];

  // Write port: store the incoming word when enabled.
  // NOTE: the array has no reset; the pointers define what is valid, and
  // resetting every word would turn a compact register file into flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_rf.sv
// Synchronous FIFO on a 1R/1W register file: valid/ready on both sides,
// occupancy count, almost-full/almost-empty flags and synchronous flush.
module sync_fifo_rf
  import fifo_pkg::*;
#(
  parameter int ADDRW     = 4,
  parameter int DATAW     = 8,
  parameter int AFULL_TH  = 2**ADDRW - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_wr_valid,
  input  logic [DATAW-1:0] i_wr_data,
  output logic             o_wr_ready,
  output logic             o_rd_valid,
  output logic [DATAW-1:0] o_rd_data,
  input  logic             i_rd_ready,
  output logic [ADDRW:0]   o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty
);

  localparam int PTRW = ptr_width(ADDRW);

  typedef logic [PTRW-1:0] ptr_t;

  localparam ptr_t AFULL_C  = ptr_t'(AFULL_TH);
  localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_TH);

  if (!afull_th_legal(ADDRW, AFULL_TH)) begin : g_bad_afull
    $error("sync_fifo_rf: AFULL_TH out of range 1..DEPTH");
  end
  if (!aempty_th_legal(ADDRW, AEMPTY_TH)) begin : g_bad_aempty
    $error("sync_fifo_rf: AEMPTY_TH out of range 0..DEPTH-1");
  end

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  ptr_t count;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic clear;

  // Status is derived from registered pointers only, so ready never
  // depends combinationally on the consumer's ready.
  assign full  = (wr_ptr[ADDRW-1:0] == rd_ptr[ADDRW-1:0]) &&
                 (wr_ptr[ADDRW] != rd_ptr[ADDRW]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign clear = rst || i_flush;
  assign push  = i_wr_valid && !full;
  assign pop   = !empty && i_rd_ready;

  // Pointer registers: clear wins over any same-cycle push/pop.
  // NOTE: non-blocking assignments keep every flop updating from the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  fifo_mem #(
    .ADDRW (ADDRW),
    .DATAW (DATAW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !clear),
    .wr_addr (wr_ptr[ADDRW-1:0]),
    .wr_data (i_wr_data),
    .rd_addr (rd_ptr[ADDRW-1:0]),
    .rd_data (o_rd_data)
  );

  assign o_wr_ready     = !full;
  assign o_rd_valid     = !empty;
  assign o_count        = count;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count >= AFULL_C);
  assign o_almost_empty = (count <= AEMPTY_C);

endmodule
